// File: rtl/uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// uart_cmd_rx
//   Serial command receiver for live PID gain tuning. Deserializes 8N1 bytes
//   from serial_rx, assembles 5-byte frames (HEADER, CMD, DHI, DLO, CHK with
//   CHK = CMD ^ DHI ^ DLO) and emits a one-cycle write strobe per accepted
//   frame, or a one-cycle error strobe per rejected frame/byte.
//
// Parameters
//   CLKS_PER_BIT : clocks per UART bit
//   TIMEOUT_CLKS : max idle clocks between bytes inside a frame
//   HEADER       : frame start byte
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   serial_rx  in   asynchronous serial line, idle high
//   cmd_valid  out  one-cycle strobe, frame accepted
//   cmd_addr   out  gain select (1 k_p, 2 k_i, 3 k_d), held
//   cmd_data   out  16-bit gain value, held
//   err_valid  out  one-cycle strobe, frame or byte rejected
//   err_code   out  0 framing, 1 checksum, 2 bad command, 3 timeout, held
// -----------------------------------------------------------------------------
module uart_cmd_rx #(
   parameter int          CLKS_PER_BIT = 1085,
   parameter int          TIMEOUT_CLKS = 43400,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        serial_rx,
   output logic        cmd_valid,
   output logic [1:0]  cmd_addr,
   output logic [15:0] cmd_data,
   output logic        err_valid,
   output logic [1:0]  err_code
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int BCW  = $clog2(CLKS_PER_BIT + 1);
   localparam int TCW  = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [BCW-1:0] HALF_LAST = BCW'(HALF - 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
   localparam logic [TCW-1:0] TO_LIMIT  = TCW'(TIMEOUT_CLKS);

   // --------------------------------------------------------------------------
   // Input synchronizer. rx_d is the previous rx_s, used for edge detection;
   // everything resets to the idle (high) level so no false edge after reset.
   // --------------------------------------------------------------------------
   logic sync1, rx_s, rx_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         sync1 <= serial_rx;
         rx_s  <= sync1;
         rx_d  <= rx_s;
      end
   end

   // --------------------------------------------------------------------------
   // Bit receiver
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;

   bstate_t        bstate, bstate_nxt;
   logic [BCW-1:0] bcnt, bcnt_nxt;
   logic [2:0]     bit_idx, bit_idx_nxt;
   logic [7:0]     shreg, shreg_nxt;
   logic           byte_rdy;
   logic           frame_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         bstate  <= B_IDLE;
         bcnt    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         bstate  <= bstate_nxt;
         bcnt    <= bcnt_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
      end
   end

   always_comb begin
      bstate_nxt  = bstate;
      bcnt_nxt    = bcnt + 1'b1;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      byte_rdy    = 1'b0;
      frame_err   = 1'b0;
      case (bstate)
         B_IDLE: begin
            bcnt_nxt    = '0;
            bit_idx_nxt = '0;
            // Requires a real 1->0 transition: after a framing error the line
            // may still be low, and we must see it return high first.
            if (rx_d && !rx_s) bstate_nxt = B_START;
         end
         B_START: begin
            if (bcnt == HALF_LAST) begin
               bcnt_nxt   = '0;
               bstate_nxt = rx_s ? B_IDLE : B_DATA;   // high here = glitch
            end
         end
         B_DATA: begin
            if (bcnt == BIT_LAST) begin
               bcnt_nxt    = '0;
               shreg_nxt   = {rx_s, shreg[7:1]};      // LSB first
               bit_idx_nxt = bit_idx + 1'b1;
               if (bit_idx == 3'd7) bstate_nxt = B_STOP;
            end
         end
         B_STOP: begin
            if (bcnt == BIT_LAST) begin
               bcnt_nxt   = '0;
               bstate_nxt = B_IDLE;
               if (rx_s) byte_rdy  = 1'b1;
               else      frame_err = 1'b1;
            end
         end
         default: bstate_nxt = B_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Frame parser
   // --------------------------------------------------------------------------
   typedef enum logic [2:0] {P_HUNT, P_CMD, P_DHI, P_DLO, P_CHK} pstate_t;

   pstate_t        pstate, pstate_nxt;
   logic [7:0]     cmd_b, dhi_b, dlo_b;
   logic [TCW-1:0] tcnt;
   logic           timeout;
   logic           cmd_fire, err_fire;
   logic [1:0]     err_sel;

   // Timeout only fires when no byte completes in the same cycle; a byte
   // arriving exactly at the limit still counts as on time.
   assign timeout = (pstate != P_HUNT) && !byte_rdy && (tcnt == TO_LIMIT);

   always_comb begin
      pstate_nxt = pstate;
      cmd_fire   = 1'b0;
      err_fire   = 1'b0;
      err_sel    = 2'd0;
      if (frame_err) begin
         pstate_nxt = P_HUNT;
         err_fire   = 1'b1;
         err_sel    = 2'd0;
      end else if (timeout) begin
         pstate_nxt = P_HUNT;
         err_fire   = 1'b1;
         err_sel    = 2'd3;
      end else if (byte_rdy) begin
         case (pstate)
            P_HUNT: if (shreg == HEADER) pstate_nxt = P_CMD;
            P_CMD:  pstate_nxt = P_DHI;
            P_DHI:  pstate_nxt = P_DLO;
            P_DLO:  pstate_nxt = P_CHK;
            P_CHK: begin
               pstate_nxt = P_HUNT;
               if (shreg != (cmd_b ^ dhi_b ^ dlo_b)) begin
                  err_fire = 1'b1;
                  err_sel  = 2'd1;
               end else if (cmd_b inside {8'd1, 8'd2, 8'd3}) begin
                  cmd_fire = 1'b1;
               end else begin
                  err_fire = 1'b1;
                  err_sel  = 2'd2;
               end
            end
            default: pstate_nxt = P_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pstate    <= P_HUNT;
         cmd_b     <= '0;
         dhi_b     <= '0;
         dlo_b     <= '0;
         tcnt      <= '0;
         cmd_valid <= 1'b0;
         cmd_addr  <= '0;
         cmd_data  <= '0;
         err_valid <= 1'b0;
         err_code  <= '0;
      end else begin
         pstate    <= pstate_nxt;
         cmd_valid <= cmd_fire;
         err_valid <= err_fire;
         if (cmd_fire) begin
            cmd_addr <= cmd_b[1:0];
            cmd_data <= {dhi_b, dlo_b};
         end
         if (err_fire) err_code <= err_sel;

         if (byte_rdy) begin
            case (pstate)
               P_CMD:   cmd_b <= shreg;
               P_DHI:   dhi_b <= shreg;
               P_DLO:   dlo_b <= shreg;
               default: ;
            endcase
         end

         if (pstate == P_HUNT || byte_rdy || timeout || frame_err) tcnt <= '0;
         else                                                    tcnt <= tcnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_rx
//   Bench for uart_cmd_rx with a shortened bit time. A reference model at the
//   byte/frame level predicts strobes (including their exact cycle for
//   byte-completed events); a monitor records strobes from the DUT.
// -----------------------------------------------------------------------------
module tb_uart_cmd_rx;

   localparam int CPB = 16;
   localparam int TO  = 4 * 10 * CPB;
   localparam logic [7:0] HDR = 8'hA5;
   // pin change at negedge c -> rx_s low from edge c+2; stop sampled in the
   // cycle starting at edge c+2+CPB/2+9*CPB; registered strobe one clock later
   localparam int LAT = 3 + CPB / 2 + 9 * CPB;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        serial_rx = 1'b1;
   logic        cmd_valid, err_valid;
   logic [1:0]  cmd_addr, err_code;
   logic [15:0] cmd_data;

   uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .HEADER(HDR)) dut (
      .clk(clk), .reset(reset), .serial_rx(serial_rx),
      .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .err_valid(err_valid), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;   // 0 cmd, 1 err
      int addr;
      int data;
      int code;
      int cyc;    // -1 = cycle not predicted
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   logic [7:0] fb[$];
   int last_addr = 0, last_data = 0, last_code = 0;
   int checks = 0, errors = 0;

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Monitor: records strobes, checks width and exclusivity.
   logic prev_stb = 1'b0;
   ev_t  mon_e;
   always @(negedge clk) begin
      if (cmd_valid || err_valid) begin
         mon_e.kind = cmd_valid ? 0 : 1;
         mon_e.addr = int'(cmd_addr);
         mon_e.data = int'(cmd_data);
         mon_e.code = int'(err_code);
         mon_e.cyc  = cyc;
         obs_q.push_back(mon_e);
         checks++;
         assert (!(cmd_valid && err_valid) && !prev_stb) else begin
            errors++;
            $error("FAIL strobe_shape: cmd=%0b err=%0b prev=%0b required single exclusive pulse",
                   cmd_valid, err_valid, prev_stb);
         end
      end
      prev_stb = cmd_valid || err_valid;
   end

   task automatic push_exp(input int kind, input int addr, input int data, input int code, input int c);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.code = code; e.cyc = c;
      exp_q.push_back(e);
      if (kind == 0) begin last_addr = addr; last_data = data; end
      else last_code = code;
   endtask

   // Frame-level model: collect bytes from HEADER until five are in hand.
   task automatic model_byte(input logic [7:0] b, input bit stop, input int c);
      logic [7:0] x;
      if (!stop) begin
         push_exp(1, 0, 0, 0, c + LAT);
         fb.delete();
      end else if (fb.size() != 0 || b == HDR) begin
         fb.push_back(b);
         if (fb.size() == 5) begin
            x = fb[1] ^ fb[2] ^ fb[3];
            if (fb[4] != x)                     push_exp(1, 0, 0, 1, c + LAT);
            else if (fb[1] >= 1 && fb[1] <= 3)  push_exp(0, int'(fb[1]), {fb[2], fb[3]}, 0, c + LAT);
            else                                push_exp(1, 0, 0, 2, c + LAT);
            fb.delete();
         end
      end
   endtask

   // Called at a negedge; returns at a negedge after the full stop bit.
   task automatic send_byte(input logic [7:0] b, input bit stop, input int gap);
      int c;
      c = cyc;
      serial_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serial_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      serial_rx = stop;
      repeat (CPB) @(negedge clk);
      serial_rx = 1'b1;
      model_byte(b, stop, c);
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] cm, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] ck, input int gap);
      send_byte(HDR, 1'b1, gap);
      send_byte(cm, 1'b1, gap);
      send_byte(hi, 1'b1, gap);
      send_byte(lo, 1'b1, gap);
      send_byte(ck, 1'b1, 0);
   endtask

   task automatic check_events(input string tag);
      int n;
      repeat (4) @(negedge clk);
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
         if (exp_q[i].kind == 0) begin
            chk({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
            chk({tag, "_data"}, obs_q[i].data, exp_q[i].data);
         end else begin
            chk({tag, "_code"}, obs_q[i].code, exp_q[i].code);
         end
         if (exp_q[i].cyc >= 0) chk({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      end
      chk({tag, "_held_addr"}, int'(cmd_addr), last_addr);
      chk({tag, "_held_data"}, int'(cmd_data), last_data);
      chk({tag, "_held_code"}, int'(err_code), last_code);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_cmd_valid"}, int'(cmd_valid), 0);
      chk({tag, "_err_valid"}, int'(err_valid), 0);
      chk({tag, "_cmd_addr"},  int'(cmd_addr),  0);
      chk({tag, "_cmd_data"},  int'(cmd_data),  0);
      chk({tag, "_err_code"},  int'(err_code),  0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] cm, hi, lo, ck, g;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_zero("reset");

      // valid frame
      send_frame(8'h01, 8'h00, 8'hC8, 8'hC9, 0);
      check_events("valid");

      // checksum error, then good frame
      send_frame(8'h02, 8'h00, 8'h01, 8'h00, 0);
      check_events("chksum");
      send_frame(8'h02, 8'h00, 8'h05, 8'h07, 3);
      check_events("after_chksum");

      // bad command; garbage before a frame
      send_frame(8'h07, 8'h12, 8'h34, 8'h21, 0);
      check_events("badcmd");
      send_byte(8'h3C, 1'b1, 0);
      send_byte(8'hFF, 1'b1, 5);
      send_frame(8'h03, 8'h12, 8'h34, 8'h25, 0);
      check_events("garbage");

      // glitch shorter than half a bit
      serial_rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      serial_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check_events("glitch");

      // framing error inside a frame, then clean frame
      send_byte(HDR, 1'b1, 0);
      send_byte(8'h01, 1'b1, 0);
      send_byte(8'h00, 1'b0, 2 * CPB);
      check_events("framing");
      send_frame(8'h01, 8'hAB, 8'hCD, 8'h01 ^ 8'hAB ^ 8'hCD, 0);
      check_events("after_framing");

      // timeout
      send_byte(HDR, 1'b1, 0);
      send_byte(8'h03, 1'b1, 0);
      push_exp(1, 0, 0, 3, -1);
      fb.delete();
      repeat (TO + 100) @(negedge clk);
      check_events("timeout");
      send_frame(8'h03, 8'h01, 8'hF4, 8'hF6, 0);
      check_events("after_timeout");

      // back-to-back frames, zero idle
      send_frame(8'h01, 8'h12, 8'h34, 8'h01 ^ 8'h12 ^ 8'h34, 0);
      send_frame(8'h02, 8'hA5, 8'hA5, 8'h02, 0);
      check_events("b2b");

      // reset during DHI
      send_byte(HDR, 1'b1, 0);
      send_byte(8'h02, 1'b1, 0);
      serial_rx = 1'b0;
      repeat (2 * CPB) @(negedge clk);
      serial_rx = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      fb.delete();
      last_addr = 0; last_data = 0; last_code = 0;
      check_zero("midreset");
      repeat (2 * CPB) @(negedge clk);
      check_events("midreset");
      send_frame(8'h02, 8'h03, 8'hE8, 8'h02 ^ 8'h03 ^ 8'hE8, 0);
      check_events("after_reset");

      // randomized frames
      for (int f = 0; f < 14; f++) begin
         if ($urandom_range(3) == 0) begin
            g = 8'($urandom_range(255));
            if (g == HDR) g = 8'h3C;
            send_byte(g, 1'b1, $urandom_range(20));
         end
         cm = 8'($urandom_range(4));
         hi = 8'($urandom_range(255));
         lo = 8'($urandom_range(255));
         ck = cm ^ hi ^ lo;
         if ($urandom_range(3) == 0) ck = ck ^ (8'h01 << $urandom_range(7));
         send_frame(cm, hi, lo, ck, ($urandom_range(1) == 0) ? 0 : $urandom_range(30));
         check_events("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
